// File: rtl/ex_mem_skid_pkg.sv
// Shared constants and types for the EX->MEM skid-buffered pipeline stage.
// Holds the NOP encoding, default bus widths and the handshake state type.
package ex_mem_skid_pkg;

    // Default widths of the surrounding datapath
    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam int ALU_OP_BUS   = 8;

    // NOP encoding presented to memory whenever no entry is valid
    localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR  = '0;
    localparam logic [ALU_OP_BUS-1:0]   EXE_NOP       = '0;
    localparam logic [REG_BUS-1:0]      ZERO_WORD     = '0;
    localparam logic                    WRITE_ENABLE  = 1'b1;
    localparam logic                    WRITE_DISABLE = ~WRITE_ENABLE;

    // EMPTY: nothing held; BUSY: main slot holds an entry; FULL: main and skid hold entries
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Width of the packed payload carried through the stage
    function automatic int payload_width(input int reg_addr_w, input int aluop_w,
                                         input int data_w, input int hilo_en);
        return reg_addr_w + 1 + aluop_w + 3 * data_w + ((hilo_en != 0) ? (2 * data_w + 1) : 0);
    endfunction

endpackage

// File: rtl/ex_mem_skid_pipe_slot.sv
// One storage slot of the skid stage: a payload register plus a valid bit.
// The payload output shows CLEAR_VAL whenever the slot is empty.
module pipe_slot #(
    parameter int           W         = 8,
    parameter logic [W-1:0] CLEAR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Slot register: clear wins over load so a flush always empties the slot
    always_ff @(posedge clk) begin
        // NOTE: the payload is reset as well as the valid bit, because it is visible on the outputs as the NOP encoding.
        if (rst || i_clear) begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            r_valid <= 1'b0;
            r_data  <= CLEAR_VAL;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_valid ? r_data : CLEAR_VAL;

endmodule

// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline stage with a valid/ready handshake and a two-entry skid
// buffer. ex_ready is registered so a memory stall never reaches execute
// combinationally. Also counts downstream stall cycles (saturating).
module ex_mem_skid
    import ex_mem_skid_pkg::*;
#(
    parameter int DATA_W     = REG_BUS,
    parameter int REG_ADDR_W = REG_ADDR_BUS,
    parameter int ALUOP_W    = ALU_OP_BUS,
    parameter int HILO_EN    = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [DATA_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_reg2,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic                  ex_whilo,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [ALUOP_W-1:0]    mem_aluop,
    output logic [DATA_W-1:0]     mem_mem_addr,
    output logic [DATA_W-1:0]     mem_reg2,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic                  mem_whilo,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int PAYLOAD_W = payload_width(REG_ADDR_W, ALUOP_W, DATA_W, HILO_EN);
    localparam int HILO_W    = (HILO_EN != 0) ? (2 * DATA_W + 1) : 0;
    localparam int BASE_W    = PAYLOAD_W - HILO_W;

    // Bit offsets of the base fields; HI/LO (when present) occupy the low HILO_W bits
    localparam int OFF_REG2  = HILO_W;
    localparam int OFF_ADDR  = OFF_REG2 + DATA_W;
    localparam int OFF_WDATA = OFF_ADDR + DATA_W;
    localparam int OFF_ALUOP = OFF_WDATA + DATA_W;
    localparam int OFF_WREG  = OFF_ALUOP + ALUOP_W;
    localparam int OFF_WD    = OFF_WREG + 1;

    localparam logic [BASE_W-1:0] NOP_BASE = {REG_ADDR_W'(NOP_REG_ADDR), WRITE_DISABLE,
                                              ALUOP_W'(EXE_NOP), DATA_W'(ZERO_WORD),
                                              DATA_W'(ZERO_WORD), DATA_W'(ZERO_WORD)};
    localparam logic [PAYLOAD_W-1:0] NOP_PAYLOAD = PAYLOAD_W'(NOP_BASE) << HILO_W;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_ex_ready;
    logic [CNT_W-1:0]       r_stall_cnt;

    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_main_load;
    logic                   w_main_clear;
    logic                   w_main_from_skid;
    logic                   w_skid_load;
    logic                   w_skid_clear;
    logic [PAYLOAD_W-1:0]   w_in_payload;
    logic [PAYLOAD_W-1:0]   w_main_d;
    logic [PAYLOAD_W-1:0]   w_main_data;
    logic [PAYLOAD_W-1:0]   w_skid_data;
    logic                   w_main_valid;
    logic                   w_skid_valid;

    assign w_in_fire  = ex_valid & r_ex_ready;
    assign w_out_fire = w_main_valid & mem_ready;

    // Pack the execute fields and unpack the main slot onto the memory outputs
    generate
        if (HILO_EN != 0) begin : g_hilo
            assign w_in_payload = {ex_wd, ex_wreg, ex_aluop, ex_wdata, ex_mem_addr, ex_reg2,
                                   ex_hi, ex_lo, ex_whilo};
            assign mem_hi    = w_main_data[DATA_W + 1 +: DATA_W];
            assign mem_lo    = w_main_data[1 +: DATA_W];
            assign mem_whilo = w_main_data[0];
        end else begin : g_no_hilo
            logic w_unused_hilo;
            assign w_unused_hilo = ^{ex_hi, ex_lo, ex_whilo};
            assign w_in_payload  = {ex_wd, ex_wreg, ex_aluop, ex_wdata, ex_mem_addr, ex_reg2};
            assign mem_hi    = '0;
            assign mem_lo    = '0;
            assign mem_whilo = 1'b0;
        end
    endgenerate

    assign mem_wd       = w_main_data[OFF_WD +: REG_ADDR_W];
    assign mem_wreg     = w_main_data[OFF_WREG];
    assign mem_aluop    = w_main_data[OFF_ALUOP +: ALUOP_W];
    assign mem_wdata    = w_main_data[OFF_WDATA +: DATA_W];
    assign mem_mem_addr = w_main_data[OFF_ADDR +: DATA_W];
    assign mem_reg2     = w_main_data[OFF_REG2 +: DATA_W];

    assign mem_valid = w_main_valid;
    assign ex_ready  = r_ex_ready;
    assign stall_cnt = r_stall_cnt;

    // Main slot refills from the skid when draining FULL, otherwise from execute
    assign w_main_d = w_main_from_skid ? w_skid_data : w_in_payload;

    pipe_slot #(
        .W         (PAYLOAD_W),
        .CLEAR_VAL (NOP_PAYLOAD)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_d),
        .o_valid (w_main_valid),
        .o_data  (w_main_data)
    );

    pipe_slot #(
        .W         (PAYLOAD_W),
        .CLEAR_VAL (NOP_PAYLOAD)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_in_payload),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
    );

    // Next-state and slot control; flush overrides both handshakes
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
        w_state_next     = r_state;
        w_main_load      = 1'b0;
        w_main_clear     = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;

        if (flush) begin
            w_state_next = ST_EMPTY;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_load  = 1'b1;
                        w_state_next = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_load = 1'b1;
                    end else if (w_in_fire) begin
                        w_skid_load  = 1'b1;
                        w_state_next = ST_FULL;
                    end else if (w_out_fire) begin
                        w_main_clear = 1'b1;
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                        w_state_next     = ST_BUSY;
                    end
                end
                default: begin
                    w_state_next = ST_EMPTY;
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                end
            endcase
        end
    end

    // State register and registered ex_ready (low only while both slots are occupied)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_ex_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_ex_ready <= (w_state_next != ST_FULL);
        end
    end

    // Saturating count of cycles where memory holds off a valid entry; flush does not clear it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_main_valid && !mem_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // The skid valid bit is implied by the FULL state; it is kept for symmetry of the slot
    logic w_unused_skid;
    assign w_unused_skid = w_skid_valid;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Self-checking bench for ex_mem_skid: a queue-based model of the stage checked
// every cycle against two instances (defaults, and HILO_EN=0 with CNT_W=4),
// plus directed scenarios with hand-computed literal expectations.
module tb_ex_mem_skid;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [7:0]  aluop;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic        mem_ready = 1'b0;
    logic [4:0]  ex_wd = '0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_wdata = '0;
    logic [7:0]  ex_aluop = '0;
    logic [31:0] ex_mem_addr = '0;
    logic [31:0] ex_reg2 = '0;
    logic [31:0] ex_hi = '0;
    logic [31:0] ex_lo = '0;
    logic        ex_whilo = 1'b0;

    logic        d1_ex_ready, d1_mem_valid, d1_mem_wreg, d1_mem_whilo;
    logic [4:0]  d1_mem_wd;
    logic [7:0]  d1_mem_aluop;
    logic [31:0] d1_mem_wdata, d1_mem_addr, d1_mem_reg2, d1_mem_hi, d1_mem_lo;
    logic [15:0] d1_stall_cnt;

    logic        d2_ex_ready, d2_mem_valid, d2_mem_wreg, d2_mem_whilo;
    logic [4:0]  d2_mem_wd;
    logic [7:0]  d2_mem_aluop;
    logic [31:0] d2_mem_wdata, d2_mem_addr, d2_mem_reg2, d2_mem_hi, d2_mem_lo;
    logic [3:0]  d2_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_mem_skid u_dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(d1_ex_ready),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_aluop(ex_aluop),
        .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .ex_whilo(ex_whilo), .mem_valid(d1_mem_valid), .mem_ready(mem_ready),
        .mem_wd(d1_mem_wd), .mem_wreg(d1_mem_wreg), .mem_wdata(d1_mem_wdata),
        .mem_aluop(d1_mem_aluop), .mem_mem_addr(d1_mem_addr), .mem_reg2(d1_mem_reg2),
        .mem_hi(d1_mem_hi), .mem_lo(d1_mem_lo), .mem_whilo(d1_mem_whilo),
        .stall_cnt(d1_stall_cnt)
    );

    ex_mem_skid #(.HILO_EN(0), .CNT_W(4)) u_dut_nh (
        .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_ready(d2_ex_ready),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_aluop(ex_aluop),
        .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .ex_whilo(ex_whilo), .mem_valid(d2_mem_valid), .mem_ready(mem_ready),
        .mem_wd(d2_mem_wd), .mem_wreg(d2_mem_wreg), .mem_wdata(d2_mem_wdata),
        .mem_aluop(d2_mem_aluop), .mem_mem_addr(d2_mem_addr), .mem_reg2(d2_mem_reg2),
        .mem_hi(d2_mem_hi), .mem_lo(d2_mem_lo), .mem_whilo(d2_mem_whilo),
        .stall_cnt(d2_stall_cnt)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a FIFO of at most two entries ----------------
    entry_t q[$];
    int     m_cnt1 = 0;
    int     m_cnt2 = 0;
    bit     m_live = 1'b0;

    always @(posedge clk) begin
        entry_t e;
        bit     acc, pop;
        e = '{wd: ex_wd, wreg: ex_wreg, aluop: ex_aluop, wdata: ex_wdata, addr: ex_mem_addr,
              reg2: ex_reg2, hi: ex_hi, lo: ex_lo, whilo: ex_whilo};
        if (rst) begin
            q.delete();
            m_cnt1 = 0;
            m_cnt2 = 0;
            m_live = 1'b1;
        end else begin
            acc = ex_valid && (q.size() < 2);
            pop = (q.size() > 0) && mem_ready;
            if ((q.size() > 0) && !mem_ready) begin
                if (m_cnt1 < 65535) m_cnt1++;
                if (m_cnt2 < 15)    m_cnt2++;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    always @(negedge clk) begin
        entry_t exp1, exp2, act1, act2;
        if (m_live) begin
            exp1 = (q.size() > 0) ? q[0] : '0;
            exp2 = exp1;
            exp2.hi = '0;
            exp2.lo = '0;
            exp2.whilo = 1'b0;
            act1 = '{wd: d1_mem_wd, wreg: d1_mem_wreg, aluop: d1_mem_aluop, wdata: d1_mem_wdata,
                     addr: d1_mem_addr, reg2: d1_mem_reg2, hi: d1_mem_hi, lo: d1_mem_lo,
                     whilo: d1_mem_whilo};
            act2 = '{wd: d2_mem_wd, wreg: d2_mem_wreg, aluop: d2_mem_aluop, wdata: d2_mem_wdata,
                     addr: d2_mem_addr, reg2: d2_mem_reg2, hi: d2_mem_hi, lo: d2_mem_lo,
                     whilo: d2_mem_whilo};
            check("d1_ex_ready",  256'(d1_ex_ready),  256'(q.size() < 2));
            check("d1_mem_valid", 256'(d1_mem_valid), 256'(q.size() > 0));
            check("d1_payload",   256'(act1),         256'(exp1));
            check("d1_stall_cnt", 256'(d1_stall_cnt), 256'(m_cnt1));
            check("d2_ex_ready",  256'(d2_ex_ready),  256'(q.size() < 2));
            check("d2_mem_valid", 256'(d2_mem_valid), 256'(q.size() > 0));
            check("d2_payload",   256'(act2),         256'(exp2));
            check("d2_stall_cnt", 256'(d2_stall_cnt), 256'(m_cnt2));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [31:0] d);
        ex_valid    = v;
        ex_wdata    = d;
        ex_wd       = d[4:0];
        ex_wreg     = 1'b1;
        ex_aluop    = d[7:0] ^ 8'h5A;
        ex_mem_addr = d + 32'd4;
        ex_reg2     = ~d;
        ex_hi       = {d[15:0], d[31:16]};
        ex_lo       = d ^ 32'hA5A5_A5A5;
        ex_whilo    = d[0];
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        cyc();
        cyc();
        check("reset_mem_valid", 256'(d1_mem_valid), 256'(0));
        check("reset_ex_ready",  256'(d1_ex_ready),  256'(1));
        check("reset_stall_cnt", 256'(d1_stall_cnt), 256'(0));

        // Reset mid-traffic: A in main, B in skid, C refused, then rst while FULL
        rst = 1'b0;
        mem_ready = 1'b0;
        drive(1'b1, 32'h0000_0011); cyc();
        drive(1'b1, 32'h0000_0022); cyc();
        check("full_ex_ready", 256'(d1_ex_ready), 256'(0));
        drive(1'b1, 32'h0000_0033); cyc();
        rst = 1'b1;
        ex_valid = 1'b0;
        cyc();
        check("rst_mid_mem_valid", 256'(d1_mem_valid), 256'(0));
        check("rst_mid_aluop",     256'(d1_mem_aluop), 256'(0));
        check("rst_mid_ex_ready",  256'(d1_ex_ready),  256'(1));
        check("rst_mid_stall_cnt", 256'(d1_stall_cnt), 256'(0));
        rst = 1'b0;

        // Streaming: 8 back-to-back entries with mem_ready held high
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h1000 + 32'(i));
            cyc();
            check("stream_wdata", 256'(d1_mem_wdata), 256'(32'h1000 + 32'(i)));
        end
        drive(1'b0, 32'h0);
        cyc();
        check("stream_drained",   256'(d1_mem_valid), 256'(0));
        check("stream_stall_cnt", 256'(d1_stall_cnt), 256'(0));

        // Skid: A held, B skidded, C waits; four stalled cycles, then release
        mem_ready = 1'b0;
        drive(1'b1, 32'h2000_000A); cyc();
        drive(1'b1, 32'h2000_000B); cyc();
        check("skid_ex_ready_low", 256'(d1_ex_ready), 256'(0));
        drive(1'b1, 32'h2000_000C); cyc();
        cyc();
        cyc();
        check("skid_stall_cnt", 256'(d1_stall_cnt), 256'(4));
        check("skid_hold_a",    256'(d1_mem_wdata), 256'(32'h2000_000A));
        mem_ready = 1'b1;
        cyc();
        check("skid_out_b",       256'(d1_mem_wdata), 256'(32'h2000_000B));
        check("skid_ex_ready_up", 256'(d1_ex_ready),  256'(1));
        cyc();
        check("skid_out_c", 256'(d1_mem_wdata), 256'(32'h2000_000C));
        drive(1'b0, 32'h0);
        cyc();
        check("skid_drained",     256'(d1_mem_valid), 256'(0));
        check("skid_stall_final", 256'(d1_stall_cnt), 256'(4));

        // Flush vs fire: flush in FULL with ex_valid and mem_ready both high
        mem_ready = 1'b0;
        drive(1'b1, 32'h3000_000D); cyc();
        drive(1'b1, 32'h3000_000E); cyc();
        flush = 1'b1;
        mem_ready = 1'b1;
        drive(1'b1, 32'h3333_3333);
        cyc();
        check("flush_mem_valid", 256'(d1_mem_valid), 256'(0));
        check("flush_wdata",     256'(d1_mem_wdata), 256'(0));
        check("flush_ex_ready",  256'(d1_ex_ready),  256'(1));
        check("flush_stall_cnt", 256'(d1_stall_cnt), 256'(5));
        flush = 1'b0;
        drive(1'b0, 32'h0);
        cyc();
        check("flush_dropped", 256'(d1_mem_valid), 256'(0));

        // HILO_EN=0: HI/LO ignored by the second instance, carried by the first
        drive(1'b1, 32'h4444_0040);
        ex_hi    = 32'hFFFF_FFFF;
        ex_whilo = 1'b1;
        cyc();
        check("nh_mem_hi",    256'(d2_mem_hi),    256'(0));
        check("nh_mem_whilo", 256'(d2_mem_whilo), 256'(0));
        check("nh_mem_wdata", 256'(d2_mem_wdata), 256'(32'h4444_0040));
        check("hl_mem_hi",    256'(d1_mem_hi),    256'(32'hFFFF_FFFF));
        check("hl_mem_whilo", 256'(d1_mem_whilo), 256'(1));
        drive(1'b0, 32'h0);
        cyc();

        // Saturation: clear counters, hold one entry stalled for 20 cycles
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mem_ready = 1'b0;
        drive(1'b1, 32'h5555_0005); cyc();
        drive(1'b0, 32'h0);
        for (int i = 0; i < 20; i++) cyc();
        check("sat_cnt4",  256'(d2_stall_cnt), 256'(15));
        check("sat_cnt16", 256'(d1_stall_cnt), 256'(20));
        mem_ready = 1'b1;
        cyc();
        check("sat_drained", 256'(d1_mem_valid), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
